mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter on the native valid/ready memory bus (addr/wdata/wstrb/rdata).
- Shares the crypto MMIO/memory block between the PicoRV32 core (m0) and a second requester (m1, DMA/debug host).
- Grant is held for a whole transaction.
- Includes a per-transaction watchdog so a hung slave cannot deadlock the core.

---
 rtl/mem_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master valid/ready memory bus arbiter with a per-transaction slave watchdog.
// Latency: grant registered in IDLE, slave request next cycle, one IDLE cycle between transactions.
// Backpressure: losing master holds valid until served; a stalled slave is cut off after TIMEOUT_CYCLES.
module mem_bus_arbiter #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                FIXED_PRIO     = 0,
  parameter int                TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_we,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          owner,
  output logic                timeout_err,
  input  logic                err_clr
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int WD_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];

  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_t;

  state_t            state;
  logic              last_grant;  // 1 = m1 was served last
  logic [WD_W-1:0]   wd_cnt;
  logic              busy_m0, busy_m1;
  logic              req_vld, wd_exp, xfer_done, fin;
  logic              pick_m0;

  always_comb begin
    busy_m0   = (state == BUSY_M0);
    busy_m1   = (state == BUSY_M1);
    req_vld   = (busy_m0 & m0_valid) | (busy_m1 & m1_valid);
    // A same-cycle s_ready beats expiry, so the watchdog only fires on a stalled slave.
    wd_exp    = (TIMEOUT_CYCLES > 0) && req_vld && !s_ready && (wd_cnt == WD_LAST);
    s_valid   = req_vld & ~wd_exp;
    xfer_done = s_valid & s_ready;
    fin       = xfer_done | wd_exp;
    m0_ready  = busy_m0 & fin;
    m1_ready  = busy_m1 & fin;
    m0_rdata  = (busy_m0 && wd_exp) ? TIMEOUT_RDATA : s_rdata;
    m1_rdata  = (busy_m1 && wd_exp) ? TIMEOUT_RDATA : s_rdata;
    pick_m0   = m0_valid & (~m1_valid | (FIXED_PRIO != 0) | last_grant);
  end

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (owner == 2'b01) begin
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else if (owner == 2'b10) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end
    s_we = |s_wstrb;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      owner       <= 2'b00;
      last_grant  <= 1'b1;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (wd_exp)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_m0) begin
            state  <= BUSY_M0;
            owner  <= 2'b01;
            wd_cnt <= '0;
          end else if (m1_valid) begin
            state  <= BUSY_M1;
            owner  <= 2'b10;
            wd_cnt <= '0;
          end
        end
        BUSY_M0, BUSY_M1: begin
          if (fin) begin
            state      <= IDLE;
            owner      <= 2'b00;
            last_grant <= busy_m1;
          end else if (!req_vld) begin
            // Master abandoned the request: release the bus without touching fairness.
            state <= IDLE;
            owner <= 2'b00;
          end else if (!s_ready) begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          owner <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] TO_RDATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid, s_ready, err_clr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        rr_m0_ready, rr_m1_ready, rr_s_valid, rr_s_we, rr_terr;
  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
  logic [3:0]  rr_s_wstrb;
  logic [1:0]  rr_owner;
  logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_we, fp_terr;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_wstrb;
  logic [1:0]  fp_owner;

  logic        sel_fp;
  logic        obs_m0_ready, obs_m1_ready, obs_s_valid, obs_s_we, obs_terr;
  logic [31:0] obs_m0_rdata, obs_m1_rdata, obs_s_addr, obs_s_wdata;
  logic [3:0]  obs_s_wstrb;
  logic [1:0]  obs_owner;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: who is being served, how long it has waited, who was served last.
  logic [1:0] md_own;
  logic       md_last;
  int         md_wd;
  logic       md_err;
  logic       md_fixed;
  logic       last_r0, last_r1;
  logic       hang;

  logic [1:0] exp_rr [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
  logic [1:0] exp_fp [8] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};

  always #10 clk = ~clk;

  mem_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(TO)) dut_rr (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(rr_m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(rr_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(rr_m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(rr_m1_rdata),
    .s_valid(rr_s_valid), .s_ready(s_ready), .s_addr(rr_s_addr), .s_wdata(rr_s_wdata),
    .s_wstrb(rr_s_wstrb), .s_we(rr_s_we), .s_rdata(s_rdata),
    .owner(rr_owner), .timeout_err(rr_terr), .err_clr(err_clr)
  );

  mem_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(TO)) dut_fp (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(fp_m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(fp_m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_ready(s_ready), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_wstrb(fp_s_wstrb), .s_we(fp_s_we), .s_rdata(s_rdata),
    .owner(fp_owner), .timeout_err(fp_terr), .err_clr(err_clr)
  );

  assign obs_m0_ready = sel_fp ? fp_m0_ready : rr_m0_ready;
  assign obs_m1_ready = sel_fp ? fp_m1_ready : rr_m1_ready;
  assign obs_m0_rdata = sel_fp ? fp_m0_rdata : rr_m0_rdata;
  assign obs_m1_rdata = sel_fp ? fp_m1_rdata : rr_m1_rdata;
  assign obs_s_valid  = sel_fp ? fp_s_valid  : rr_s_valid;
  assign obs_s_addr   = sel_fp ? fp_s_addr   : rr_s_addr;
  assign obs_s_wdata  = sel_fp ? fp_s_wdata  : rr_s_wdata;
  assign obs_s_wstrb  = sel_fp ? fp_s_wstrb  : rr_s_wstrb;
  assign obs_s_we     = sel_fp ? fp_s_we     : rr_s_we;
  assign obs_owner    = sel_fp ? fp_owner    : rr_owner;
  assign obs_terr     = sel_fp ? fp_terr     : rr_terr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_own  = 2'b00;
    md_last = 1'b1;
    md_wd   = 0;
    md_err  = 1'b0;
  endtask

  task automatic model_check();
    logic        e_vld, e_exp, e_sv, e_r0, e_r1;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    e_vld = (md_own == 2'b01) ? m0_valid : (md_own == 2'b10) ? m1_valid : 1'b0;
    e_exp = e_vld && !s_ready && (md_wd == TO - 1);
    e_sv  = e_vld && !e_exp;
    e_r0  = (md_own == 2'b01) && ((e_sv && s_ready) || e_exp);
    e_r1  = (md_own == 2'b10) && ((e_sv && s_ready) || e_exp);
    e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
    if (md_own == 2'b01) begin
      e_addr = m0_addr; e_wdata = m0_wdata; e_wstrb = m0_wstrb;
    end else if (md_own == 2'b10) begin
      e_addr = m1_addr; e_wdata = m1_wdata; e_wstrb = m1_wstrb;
    end
    chk("owner", 64'(obs_owner), 64'(md_own));
    chk("s_valid", 64'(obs_s_valid), 64'(e_sv));
    chk("m0_ready", 64'(obs_m0_ready), 64'(e_r0));
    chk("m1_ready", 64'(obs_m1_ready), 64'(e_r1));
    chk("timeout_err", 64'(obs_terr), 64'(md_err));
    chk("s_addr", 64'(obs_s_addr), 64'(e_addr));
    chk("s_wdata", 64'(obs_s_wdata), 64'(e_wdata));
    chk("s_wstrb", 64'(obs_s_wstrb), 64'(e_wstrb));
    chk("s_we", 64'(obs_s_we), 64'(|e_wstrb));
    if (e_r0) chk("m0_rdata", 64'(obs_m0_rdata), 64'(e_exp ? TO_RDATA : s_rdata));
    if (e_r1) chk("m1_rdata", 64'(obs_m1_rdata), 64'(e_exp ? TO_RDATA : s_rdata));
    last_r0 = e_r0;
    last_r1 = e_r1;
    if (!resetn) begin
      model_reset();
    end else begin
      if (e_exp) md_err = 1'b1;
      else if (err_clr) md_err = 1'b0;
      if (md_own == 2'b00) begin
        if (m0_valid && (!m1_valid || md_fixed || md_last)) begin
          md_own = 2'b01; md_wd = 0;
        end else if (m1_valid) begin
          md_own = 2'b10; md_wd = 0;
        end
      end else if (e_r0 || e_r1) begin
        md_last = e_r1;
        md_own  = 2'b00;
      end else if (!e_vld) begin
        md_own = 2'b00;
      end else if (!s_ready) begin
        md_wd++;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic fin_cyc();
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    at_neg();
    fin_cyc();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; sel_fp = 1'b0; md_fixed = 1'b0; hang = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; err_clr = 1'b0;
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_rdata = '0; last_r0 = 1'b0; last_r1 = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Single m0 read, slave answers on the second BUSY cycle.
    m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0; m0_wdata = 32'h0;
    at_neg(); chk("t1_idle_svalid", 64'(obs_s_valid), 64'd0); fin_cyc();
    at_neg(); chk("t1_svalid", 64'(obs_s_valid), 64'd1); chk("t1_owner", 64'(obs_owner), 64'd1); fin_cyc();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    at_neg(); chk("t1_ready", 64'(obs_m0_ready), 64'd1); chk("t1_rdata", 64'(obs_m0_rdata), 64'h1234_5678);
    fin_cyc();
    m0_valid = 1'b0; s_ready = 1'b0;
    at_neg(); chk("t1_owner_back", 64'(obs_owner), 64'd0); fin_cyc();

    // Continuous contention, round robin.
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
    m0_addr = 32'h100; m1_addr = 32'h200;
    for (int i = 0; i < 8; i++) begin
      s_rdata = $urandom;
      at_neg(); chk("rr_seq", 64'(obs_owner), 64'(exp_rr[i])); fin_cyc();
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick();

    // Same contention on the fixed-priority instance; m1 only wins once m0 goes quiet.
    sel_fp = 1'b1; md_fixed = 1'b1;
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_rdata = $urandom;
      at_neg(); chk("fp_seq", 64'(obs_owner), 64'(exp_fp[i])); fin_cyc();
    end
    m0_valid = 1'b0;
    at_neg(); chk("fp_idle", 64'(obs_owner), 64'd0); fin_cyc();
    at_neg(); chk("fp_m1_grant", 64'(obs_owner), 64'd2); fin_cyc();
    m1_valid = 1'b0;
    tick();
    sel_fp = 1'b0; md_fixed = 1'b0;
    do_reset();

    // m1 write to a hung slave: watchdog fires on the 8th BUSY cycle.
    m1_valid = 1'b1; m1_addr = 32'h0000_0040; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
    s_ready = 1'b0;
    tick();
    for (int k = 1; k <= TO; k++) begin
      at_neg();
      chk("to_we", 64'(obs_s_we), 64'd1);
      chk("to_wstrb", 64'(obs_s_wstrb), 64'd3);
      chk("to_ready", 64'(obs_m1_ready), 64'(k == TO));
      if (k == TO) begin
        chk("to_rdata", 64'(obs_m1_rdata), 64'(TO_RDATA));
        chk("to_svalid", 64'(obs_s_valid), 64'd0);
      end
      fin_cyc();
    end
    m1_valid = 1'b0; s_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at_neg(); chk("to_err_sticky", 64'(obs_terr), 64'd1); chk("to_late_ready", 64'(obs_m1_ready), 64'd0);
      fin_cyc();
    end
    s_ready = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    at_neg(); chk("to_err_clr", 64'(obs_terr), 64'd0); fin_cyc();

    // Asynchronous reset in the middle of an m0 transaction.
    m0_valid = 1'b1; m0_addr = 32'h0000_0020; m0_wstrb = 4'h0; s_ready = 1'b0;
    tick();
    #2; chk("rst_pre_svalid", 64'(obs_s_valid), 64'd1);
    s_ready = 1'b1; #1; chk("rst_pre_ready", 64'(obs_m0_ready), 64'd1);
    resetn = 1'b0; #1;
    chk("rst_svalid", 64'(obs_s_valid), 64'd0);
    chk("rst_ready", 64'(obs_m0_ready), 64'd0);
    chk("rst_owner", 64'(obs_owner), 64'd0);
    model_reset();
    m1_valid = 1'b1; m1_wstrb = 4'h0;
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();
    at_neg(); chk("rst_first_m0", 64'(obs_owner), 64'd1); fin_cyc();
    m0_valid = 1'b0;
    tick();
    at_neg(); chk("rst_then_m1", 64'(obs_owner), 64'd2); fin_cyc();
    m1_valid = 1'b0; s_ready = 1'b0;
    tick();

    // s_ready lands exactly on the expiry cycle: normal completion wins.
    m0_valid = 1'b1; m0_addr = 32'h0000_0080; m0_wstrb = 4'h0;
    tick();
    for (int k = 1; k < TO; k++) tick();
    s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
    at_neg(); chk("exp_ready", 64'(obs_m0_ready), 64'd1); chk("exp_rdata", 64'(obs_m0_rdata), 64'hCAFE_F00D);
    fin_cyc();
    m0_valid = 1'b0; s_ready = 1'b0;
    at_neg(); chk("exp_no_err", 64'(obs_terr), 64'd0); fin_cyc();

    // Master abandons its request mid-BUSY.
    m1_valid = 1'b1; m1_addr = 32'h0000_0044;
    tick();
    m1_valid = 1'b0;
    at_neg(); chk("drop_svalid", 64'(obs_s_valid), 64'd0); chk("drop_ready", 64'(obs_m1_ready), 64'd0); fin_cyc();
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (last_r0 || !m0_valid) begin
        m0_valid = ($urandom_range(0, 2) == 0);
        m0_addr  = $urandom; m0_wdata = $urandom;
        m0_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
      if (last_r1 || !m1_valid) begin
        m1_valid = ($urandom_range(0, 2) == 0);
        m1_addr  = $urandom; m1_wdata = $urandom;
        m1_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
      if ($urandom_range(0, 15) == 0) hang = ~hang;
      s_ready = hang ? 1'b0 : ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      err_clr = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
